// File: rtl/seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// seq_pattern_tx
//
// Serial pattern transmitter. A request (pattern, bit length, repeat count) is
// taken over a valid/ready handshake. The pattern is then shifted out MSB-first
// (bit [len-1] first), one bit per clock. GAP_CYC idle cycles are inserted
// between repetitions. A one-cycle done pulse follows the final bit.
//
// Handshake: a request transfers on a rising edge where req_vld_i and
// req_rdy_o are both high. req_rdy_o is high exactly while the FSM is IDLE. A
// requester that sees req_rdy_o low must keep req_vld_i and its payload stable
// until the transfer edge. Requests are never queued.
//
// Parameters
//   W_MAX    maximum pattern width in bits (2..32)
//   GAP_CYC  idle cycles between repetitions (0..15)
//   LEN_W    width of len_i, derived from W_MAX
//
// Ports
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   pat_i        pattern, bit [len-1] sent first
//   len_i        pattern length; 0 or > W_MAX means W_MAX
//   rep_i        extra repetitions (frames sent = rep_i + 1)
//   req_vld_i    request valid
//   req_rdy_o    request ready (IDLE)
//   abort_i      synchronous abort of an active transfer
//   data_o       serial data, 0 when data_vld_o is 0
//   data_vld_o   data_o carries a pattern bit
//   busy_o       transfer in progress (SHIFT or GAP)
//   done_o       one-cycle pulse after the last bit of the last frame
//   dbg_state_o  current FSM state encoding (observation only)
// -----------------------------------------------------------------------------
module seq_pattern_tx #(
  parameter int W_MAX   = 16,
  parameter int GAP_CYC = 1,
  localparam int LEN_W  = $clog2(W_MAX + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [W_MAX-1:0] pat_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [7:0]       rep_i,
  input  logic             req_vld_i,
  output logic             req_rdy_o,
  input  logic             abort_i,
  output logic             data_o,
  output logic             data_vld_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] W_MAX_L  = LEN_W'(W_MAX);
  localparam logic [3:0]       GAP_LAST = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

  state_t           state;
  state_t           state_nxt;

  // pat_q keeps the left-aligned pattern so every repetition reloads from it.
  // shreg[W_MAX-1] always holds the bit currently on data_o.
  logic [W_MAX-1:0] pat_q;
  logic [W_MAX-1:0] shreg;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bit_cnt;
  logic [7:0]       rep_cnt;
  logic [3:0]       gap_cnt;

  logic [LEN_W-1:0] len_c;
  logic [W_MAX-1:0] pat_aligned;

  logic             accept;
  logic             advance;
  logic             reload;
  logic             gap_enter;
  logic             gap_step;
  logic             last_done;

  logic             data_nxt;
  logic             vld_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  // Clamp the length, then left-align so bit [len-1] lands in the MSB.
  assign len_c       = (len_i == '0 || len_i > W_MAX_L) ? W_MAX_L : len_i;
  assign pat_aligned = pat_i << (W_MAX_L - len_c);

  assign req_rdy_o   = (state == ST_IDLE);
  assign dbg_state_o = state;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic and datapath strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    reload    = 1'b0;
    gap_enter = 1'b0;
    gap_step  = 1'b0;
    last_done = 1'b0;
    case (state)
      ST_IDLE: begin
        // abort_i has no meaning here; a coincident request still transfers.
        if (req_vld_i) begin
          accept    = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort_i) begin
          state_nxt = ST_IDLE;
        end else if (bit_cnt != '0) begin
          advance = 1'b1;
        end else if (rep_cnt == 8'd0) begin
          last_done = 1'b1;
          state_nxt = ST_IDLE;
        end else if (GAP_CYC > 0) begin
          gap_enter = 1'b1;
          state_nxt = ST_GAP;
        end else begin
          // No gap configured: next frame starts on the very next cycle.
          reload = 1'b1;
        end
      end
      ST_GAP: begin
        if (abort_i) begin
          state_nxt = ST_IDLE;
        end else if (gap_cnt == 4'd0) begin
          reload    = 1'b1;
          state_nxt = ST_SHIFT;
        end else begin
          gap_step = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: values the registered outputs take after this edge
  // ---------------------------------------------------------------------------
  always_comb begin
    data_nxt = 1'b0;
    vld_nxt  = 1'b0;
    busy_nxt = (state_nxt == ST_SHIFT) || (state_nxt == ST_GAP);
    done_nxt = last_done;
    if (accept) begin
      data_nxt = pat_aligned[W_MAX-1];
      vld_nxt  = 1'b1;
    end else if (advance) begin
      data_nxt = shreg[W_MAX-2];
      vld_nxt  = 1'b1;
    end else if (reload) begin
      data_nxt = pat_q[W_MAX-1];
      vld_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_o     <= 1'b0;
      data_vld_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      data_o     <= data_nxt;
      data_vld_o <= vld_nxt;
      busy_o     <= busy_nxt;
      done_o     <= done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: shift register and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pat_q   <= '0;
      shreg   <= '0;
      len_q   <= '0;
      bit_cnt <= '0;
      rep_cnt <= 8'd0;
      gap_cnt <= 4'd0;
    end else begin
      if (accept) begin
        pat_q   <= pat_aligned;
        shreg   <= pat_aligned;
        len_q   <= len_c;
        bit_cnt <= len_c - LEN_W'(1);
        rep_cnt <= rep_i;
      end else if (advance) begin
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt - LEN_W'(1);
      end else if (reload) begin
        shreg   <= pat_q;
        bit_cnt <= len_q - LEN_W'(1);
        rep_cnt <= rep_cnt - 8'd1;
      end
      // gap_cnt counts the remaining GAP cycles after the current one.
      if (gap_enter) begin
        gap_cnt <= GAP_LAST;
      end else if (gap_step) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_tx
//
// Two instances: dut (GAP_CYC=1) and dut0 (GAP_CYC=0). Requests push the
// expected output events (cycle number + bit or done) into per-instance
// queues; a negedge monitor pops and compares every output event it sees.
// -----------------------------------------------------------------------------
module tb_seq_pattern_tx;

  // clock / reset / stimulus
  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic [15:0] pat      = '0;
  logic [4:0]  len      = '0;
  logic [7:0]  rep      = '0;
  logic        req_vld  = 1'b0;
  logic        req_vld0 = 1'b0;
  logic        abort    = 1'b0;

  logic       req_rdy, data, data_vld, busy, done;
  logic [1:0] dbg_state;
  logic       req_rdy0, data0, data_vld0, busy0, done0;
  logic [1:0] dbg_state0;

  int cyc       = 0;
  int chk       = 0;
  int err       = 0;
  int busy_cnt  = 0;
  int busy_cnt0 = 0;

  // entry = {cycle[15:0], code}; code 2'b00/2'b01 = data bit, 2'b10 = done
  logic [17:0] exp_q[$];
  logic [17:0] exp0_q[$];

  seq_pattern_tx #(.W_MAX(16), .GAP_CYC(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .pat_i(pat), .len_i(len), .rep_i(rep),
    .req_vld_i(req_vld), .req_rdy_o(req_rdy), .abort_i(abort),
    .data_o(data), .data_vld_o(data_vld), .busy_o(busy), .done_o(done),
    .dbg_state_o(dbg_state)
  );

  seq_pattern_tx #(.W_MAX(16), .GAP_CYC(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .pat_i(pat), .len_i(len), .rep_i(rep),
    .req_vld_i(req_vld0), .req_rdy_o(req_rdy0), .abort_i(abort),
    .data_o(data0), .data_vld_o(data_vld0), .busy_o(busy0), .done_o(done0),
    .dbg_state_o(dbg_state0)
  );

  // ---------------------------------------------------------------------------
  // clock / reset block
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // scoreboard helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk++;
    if (act !== req) begin
      err++;
      $display("FAIL %s: got %0h required %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int sel, input int c, input logic [1:0] code);
    if (sel == 0) exp_q.push_back({c[15:0], code});
    else          exp0_q.push_back({c[15:0], code});
  endtask

  // Expected events of a request accepted at the edge following cycle t.
  // Only the first lim bits are expected (for aborted / reset transfers).
  task automatic expect_frames(input int sel, input int t, input logic [15:0] p,
                               input int l, input int r, input int gap,
                               input int lim, input bit with_done);
    int n = 0;
    for (int f = 0; f <= r; f++) begin
      for (int i = 0; i < l; i++) begin
        if (n < lim) push(sel, t + 1 + f * (l + gap) + i, {1'b0, p[l-1-i]});
        n++;
      end
    end
    if (with_done) push(sel, t + 1 + (r + 1) * l + r * gap, 2'b10);
  endtask

  task automatic mon(input int sel, input logic v, input logic d, input logic dn, input logic b);
    logic [17:0] got;
    logic [17:0] want;
    if (b) begin
      if (sel == 0) busy_cnt++;
      else          busy_cnt0++;
    end
    chk++;
    if (!v && d) begin
      err++;
      $display("FAIL idle_data%0d: data_o=1 required 0 while data_vld_o=0 (cyc %0d)", sel, cyc);
    end
    if (v || dn) begin
      got = {cyc[15:0], dn, d};
      chk++;
      if ((sel == 0 && exp_q.size() == 0) || (sel == 1 && exp0_q.size() == 0)) begin
        err++;
        $display("FAIL unexpected_out%0d: got vld=%0b done=%0b data=%0b at cyc %0d, required no output",
                 sel, v, dn, d, cyc);
      end else begin
        if (sel == 0) want = exp_q.pop_front();
        else          want = exp0_q.pop_front();
        if (got !== want) begin
          err++;
          $display("FAIL out%0d: got cyc %0d code %0d, required cyc %0d code %0d",
                   sel, got[17:2], got[1:0], want[17:2], want[1:0]);
        end
      end
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, data_vld, data, done, busy);
      mon(1, data_vld0, data0, done0, busy0);
    end
  end

  // ---------------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------------
  task automatic send(input int sel, input logic [15:0] p, input logic [4:0] l,
                      input logic [7:0] r, output int t);
    @(negedge clk);
    if (sel == 0) check("req_rdy", req_rdy, 1);
    else          check("req_rdy0", req_rdy0, 1);
    pat = p;
    len = l;
    rep = r;
    if (sel == 0) req_vld = 1'b1;
    else          req_vld0 = 1'b1;
    t = cyc;
  endtask

  task automatic drop();
    @(negedge clk);
    req_vld  = 1'b0;
    req_vld0 = 1'b0;
    abort    = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp0_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk++;
    if (exp_q.size() != 0 || exp0_q.size() != 0) begin
      err++;
      $display("FAIL drain_timeout: pending %0d/%0d events, required 0", exp_q.size(), exp0_q.size());
      exp_q.delete();
      exp0_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int t;
    int t2;

    // reset state
    #3;
    check("rst_rdy", req_rdy, 1);
    check("rst_vld", data_vld, 0);
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, 0);
    check("rst_rdy0", req_rdy0, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", req_rdy, 1);
    check("post_rst_state", dbg_state, 0);

    // 0x0005 len 3 rep 0: 1,0,1 then done at T+4
    busy_cnt = 0;
    send(0, 16'h0005, 5'd3, 8'd0, t);
    expect_frames(0, t, 16'h0005, 3, 0, 1, 99, 1);
    drop();
    drain();
    check("t1_busy_cycles", busy_cnt, 3);

    // rep 2 with one gap cycle: done at T+12, 11 busy cycles
    busy_cnt = 0;
    send(0, 16'h0005, 5'd3, 8'd2, t);
    expect_frames(0, t, 16'h0005, 3, 2, 1, 99, 1);
    drop();
    drain();
    check("t2_busy_cycles", busy_cnt, 11);

    // same request with no gap: 9 continuous bits, done at T+10
    busy_cnt0 = 0;
    send(1, 16'h0005, 5'd3, 8'd2, t);
    expect_frames(1, t, 16'h0005, 3, 2, 0, 99, 1);
    drop();
    drain();
    check("t3_busy_cycles", busy_cnt0, 9);

    // len 0 clamps to 16: 1010010111000011, then back-to-back single-bit frame
    busy_cnt = 0;
    send(0, 16'hA5C3, 5'd0, 8'd0, t);
    expect_frames(0, t, 16'hA5C3, 16, 0, 1, 99, 1);
    drop();
    while (cyc < t + 16) @(negedge clk);
    send(0, 16'h0001, 5'd1, 8'd0, t2);
    check("b2b_done_cycle", done, 1);
    expect_frames(0, t2, 16'h0001, 1, 0, 1, 99, 1);
    drop();
    drain();
    check("t4_busy_cycles", busy_cnt, 17);

    // abort in the 5th SHIFT cycle
    busy_cnt = 0;
    send(0, 16'h00FF, 5'd8, 8'd3, t);
    expect_frames(0, t, 16'h00FF, 8, 3, 1, 5, 0);
    drop();
    while (cyc < t + 5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abs_vld", data_vld, 0);
    check("abs_busy", busy, 0);
    check("abs_rdy", req_rdy, 1);
    check("abs_state", dbg_state, 0);
    drain();
    check("abs_busy_cycles", busy_cnt, 5);

    // abort in the GAP cycle after the first frame
    busy_cnt = 0;
    send(0, 16'h00FF, 5'd8, 8'd3, t);
    expect_frames(0, t, 16'h00FF, 8, 3, 1, 8, 0);
    drop();
    while (cyc < t + 9) @(negedge clk);
    check("gap_vld_low", data_vld, 0);
    check("gap_busy_high", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abg_vld", data_vld, 0);
    check("abg_busy", busy, 0);
    check("abg_rdy", req_rdy, 1);
    drain();
    check("abg_busy_cycles", busy_cnt, 9);

    // abort together with a request in IDLE: request wins
    busy_cnt = 0;
    send(0, 16'h0005, 5'd3, 8'd0, t);
    abort = 1'b1;
    expect_frames(0, t, 16'h0005, 3, 0, 1, 99, 1);
    drop();
    drain();
    check("abi_busy_cycles", busy_cnt, 3);

    // asynchronous reset mid-frame
    send(0, 16'h00FF, 5'd8, 8'd0, t);
    expect_frames(0, t, 16'h00FF, 8, 0, 1, 1, 0);
    drop();
    @(posedge clk);
    #1;
    check("pre_rst_vld", data_vld, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_data", data, 0);
    check("arst_vld", data_vld, 0);
    check("arst_busy", busy, 0);
    check("arst_rdy", req_rdy, 1);
    check("arst_done", done, 0);
    check("arst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // normal transfer after reset release: 1,0,1,gap,1,0,1, done
    busy_cnt = 0;
    send(0, 16'h0005, 5'd3, 8'd1, t);
    expect_frames(0, t, 16'h0005, 3, 1, 1, 99, 1);
    drop();
    drain();
    check("post_arst_busy_cycles", busy_cnt, 7);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter that drives a one-bit data line for the team's serial sequence-detector FSMs. It accepts a parallel pattern, a bit length and a repeat count over a valid/ready request handshake. It then shifts the pattern out MSB-first, one bit per clock, and inserts idle gap cycles between repetitions. It sits in front of any serial detector, either as the stimulus source in a loopback or as the on-chip framing source.

## Interface
- W_MAX, 16: maximum pattern width in bits, 2..32
- GAP_CYC, 1: idle cycles between repetitions, 0..15
- LEN_W, $clog2(W_MAX+1): width of len_i (derived; not overridden)
- clk_i  input  1  clock; all logic on rising edge
- rst_n_i  input  1  reset; asynchronous, active-low
- pat_i  input  W_MAX  pattern; bit [len-1] is transmitted first, bit [0] last
- len_i  input  LEN_W  pattern length in bits; 0 or >W_MAX is clamped to W_MAX
- rep_i  input  8  extra repetitions; total frames sent = rep_i+1
- req_vld_i  input  1  request valid
- req_rdy_o  output  1  request ready; high only in IDLE
- abort_i  input  1  synchronous abort of the active transfer
- data_o  output  1  serial data; 0 whenever data_vld_o=0
- data_vld_o  output  1  data_o carries a pattern bit this cycle
- busy_o  output  1  high in SHIFT or GAP
- done_o  output  1  one-cycle pulse after the final bit of the final repetition

## Operation
- States: IDLE, SHIFT, GAP. Encode in 2 bits; an illegal encoding returns to IDLE on the next clock.
- Request acceptance: req_vld_i & req_rdy_o sampled high at an edge. That edge captures pat_i, the clamped len_i and rep_i into internal registers. Inputs are don't-care otherwise.
- Datapath: shift register, bit counter (LEN_W bits) and repeat counter (8 bits). The original pattern is held separately so it can be reloaded for each repetition.
- IDLE -> SHIFT on acceptance. Load the shift register with the pattern, set bit_cnt = len-1 and rep_cnt = rep_i.
- SHIFT:
  - data_o = current MSB-of-frame bit, data_vld_o = 1.
  - If bit_cnt != 0: decrement bit_cnt and advance.
  - If bit_cnt == 0 and rep_cnt == 0: go to IDLE and assert done_o next cycle.
  - If bit_cnt == 0, rep_cnt != 0 and GAP_CYC > 0: go to GAP.
  - If bit_cnt == 0, rep_cnt != 0 and GAP_CYC == 0: stay in SHIFT, reload the pattern and decrement rep_cnt.
- GAP: data_o = 0, data_vld_o = 0 for exactly GAP_CYC cycles. Then go to SHIFT with the pattern reloaded, bit_cnt = len-1 and rep_cnt decremented.
- Abort:
  - abort_i high at an edge while in SHIFT or GAP: go to IDLE. data_vld_o is 0 from the next cycle and no done_o pulse is generated.
  - abort_i in IDLE is ignored. A request and an abort in the same IDLE cycle: the request is accepted.
- Requests are not queued. req_vld_i while busy_o is high is not accepted, and the requester must hold it.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): state=IDLE, data_o=0, data_vld_o=0, busy_o=0, done_o=0, req_rdy_o=1, all counters 0.
- data_o, data_vld_o, busy_o and done_o are registered. req_rdy_o is decoded from the state register.
- Request accepted at edge T: the first bit is on data_o in cycle T+1. A frame of length L occupies cycles T+1..T+L.
- The first bit of each following repetition appears GAP_CYC cycles after the previous frame's last bit.
- Total transfer length: (rep+1)*L + rep*GAP_CYC cycles of busy_o.
- done_o is high in the single cycle after the last bit. In that cycle req_rdy_o=1, so a back-to-back request accepted at that edge gives its first bit one cycle later. The minimum dead cycle between requests is therefore 1.
- Abort at edge A: data_vld_o=0, busy_o=0 and req_rdy_o=1 in cycle A+1.
- Reset asserted mid-transfer: outputs take their reset values immediately, and no done_o is generated.

## Test plan
- pat=0x0005, len=3, rep=0, GAP_CYC=1: data_o = 1,0,1 in cycles T+1..T+3 with data_vld_o high; done_o at T+4; busy_o high for 3 cycles.
- pat=0x0005, len=3, rep=2, GAP_CYC=1: data_o/data_vld_o = 1,0,1,(0,vld0),1,0,1,(0,vld0),1,0,1; done_o at T+12; busy_o high 11 cycles.
- Same request with GAP_CYC=0: continuous 1,0,1,1,0,1,1,0,1 (9 cycles), done_o at T+10.
- len=0 with pat=0xA5C3 and W_MAX=16: 16 bits sent, sequence 1010010111000011; back-to-back second request (pat=0x0001, len=1) accepted in the done_o cycle outputs a single 1 one cycle later.
- pat=0x00FF, len=8, rep=3; abort_i pulsed in the 5th SHIFT cycle: data_vld_o=0 next cycle, no done_o, req_rdy_o=1. Repeat with abort during GAP and abort+req_vld_i in IDLE, where the request must be accepted.
- rst_n_i dropped asynchronously mid-frame, between clock edges: data_o, data_vld_o and busy_o go to 0 immediately and req_rdy_o goes to 1. After release, a new request transmits normally.
